// File: rtl/ntt_bram_pkg.sv
// Shared sizing, state encoding and address helper for the NTT BRAM responder.
package ntt_bram_pkg;

    localparam int DATA_W   = 64;
    localparam int N        = 64;
    localparam int ADDR_W   = 13;
    localparam int IN_BASE  = 0;
    localparam int OUT_BASE = 64;

    localparam int WORD_W = ADDR_W - 2;
    localparam int MEM_AW = $clog2(2 * N);
    localparam int CNT_W  = $clog2(N) + 1;

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

    function automatic logic [MEM_AW-1:0] mem_idx(input int base, input logic [CNT_W-1:0] ofs);
        return MEM_AW'(base + int'(ofs));
    endfunction

endpackage

// File: rtl/ntt_bram_responder_if.sv
// Engine BRAM port plus host load/result streams, seen from the responder (slave) or driver (master).
interface ntt_bram_responder_if;
    import ntt_bram_pkg::*;

    logic [ADDR_W-1:0] BRAM_addr;
    logic              BRAM_clk;
    logic [DATA_W-1:0] BRAM_din;
    logic [DATA_W-1:0] BRAM_dout;
    logic              BRAM_en;
    logic              BRAM_we;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_we, in_valid, in_data, out_ready,
        output BRAM_dout, in_ready, out_valid, out_data, out_last
    );

    modport master (
        output BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_we, in_valid, in_data, out_ready,
        input  BRAM_dout, in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/ntt_bram_responder_tdp_ram.sv
// True dual-port 2N x DATA_W RAM, read-first, 1-cycle registered reads; array itself is never reset.
module ntt_tdp_ram
    import ntt_bram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [MEM_AW-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [MEM_AW-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout
);

    logic [DATA_W-1:0] mem [2*N];

    always_ff @(posedge clk) begin
        if (a_en && a_we) mem[a_addr] <= a_din;
        if (b_en && b_we) mem[b_addr] <= b_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout <= '0;
            b_dout <= '0;
        end else begin
            if (a_en && !a_we) a_dout <= mem[a_addr];
            if (b_en && !b_we) b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/ntt_bram_responder.sv
// Memory-side responder for the NTT engine: host load, engine run, result drain through a skid buffer.
//   state | meaning
//   LOAD  | engine held in reset, host streams N coefficients into the input region
//   RUN   | engine released, result-region writes counted until N arrive
//   DRAIN | engine held in reset, result region streamed to host, then back to LOAD
module ntt_bram_responder
    import ntt_bram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    ntt_bram_responder_if.slave   bus,
    output logic                  eng_rst,
    output logic                  busy,
    output logic                  err
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  k_q, wcnt_q, j_q, rd_q;
    logic [WORD_W-1:0] word;
    logic              in_range, is_res, a_rd, a_wr, a_wr_ok, a_oob_q, err_q, live_q;
    logic              in_rdy, load_acc, issue, pend_q, pop, out_vld, last_hs;
    logic [1:0]        cnt_q, occ;
    logic              rp_q, wp_q;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] ram_a_dout, ram_b_dout;
    logic              unused_pins;

    assign unused_pins = ^{bus.BRAM_clk, bus.BRAM_addr[1:0]};

    assign word     = bus.BRAM_addr[ADDR_W-1:2];
    assign in_range = word < WORD_W'(2 * N);
    assign is_res   = word >= WORD_W'(OUT_BASE);
    assign a_rd     = bus.BRAM_en && !bus.BRAM_we;
    assign a_wr     = bus.BRAM_en && bus.BRAM_we;

    assign out_vld  = cnt_q != 2'd0;
    assign pop      = out_vld && bus.out_ready;
    assign last_hs  = pop && (j_q == CNT_W'(N - 1));
    assign load_acc = bus.in_valid && in_rdy;
    assign occ      = cnt_q + {1'b0, pend_q};
    // A read may be issued whenever the slot it lands in is guaranteed free on return.
    assign issue    = (state_q == DRAIN) && (rd_q != CNT_W'(N)) && (occ != 2'd2 || pop);

    always_comb begin
        state_d = state_q;
        eng_rst = 1'b1;
        busy    = 1'b0;
        in_rdy  = 1'b0;
        a_wr_ok = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_rdy  = live_q && (k_q != CNT_W'(N));
                a_wr_ok = a_wr && in_range;
                if (k_q == CNT_W'(N)) state_d = RUN;
            end
            RUN: begin
                eng_rst = 1'b0;
                busy    = 1'b1;
                a_wr_ok = a_wr && in_range && is_res;
                if (wcnt_q == CNT_W'(N)) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_hs) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            k_q      <= '0;
            wcnt_q   <= '0;
            j_q      <= '0;
            rd_q     <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            rp_q     <= 1'b0;
            wp_q     <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            err_q    <= 1'b0;
            a_oob_q  <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (load_acc) k_q <= k_q + CNT_W'(1);
            if (state_q == RUN && a_wr && in_range && is_res && wcnt_q != CNT_W'(N))
                wcnt_q <= wcnt_q + CNT_W'(1);
            pend_q <= issue;
            if (issue) rd_q <= rd_q + CNT_W'(1);
            if (pend_q) begin
                buf_q[wp_q] <= ram_b_dout;
                wp_q        <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
                j_q  <= j_q + CNT_W'(1);
            end
            cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
            if (last_hs) begin
                k_q    <= '0;
                wcnt_q <= '0;
                j_q    <= '0;
                rd_q   <= '0;
                pend_q <= 1'b0;
                cnt_q  <= '0;
                rp_q   <= 1'b0;
                wp_q   <= 1'b0;
            end
            if ((bus.BRAM_en && !in_range) || (state_q == RUN && a_wr && in_range && !is_res))
                err_q <= 1'b1;
            if (a_rd) a_oob_q <= !in_range;
        end
    end

    ntt_tdp_ram u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_en   ((a_rd && in_range) || a_wr_ok),
        .a_we   (bus.BRAM_we),
        .a_addr (word[MEM_AW-1:0]),
        .a_din  (bus.BRAM_din),
        .a_dout (ram_a_dout),
        .b_en   (load_acc || issue),
        .b_we   (load_acc),
        .b_addr (load_acc ? mem_idx(IN_BASE, k_q) : mem_idx(OUT_BASE, rd_q)),
        .b_din  (bus.in_data),
        .b_dout (ram_b_dout)
    );

    assign bus.BRAM_dout = a_oob_q ? '0 : ram_a_dout;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? buf_q[rp_q] : '0;
    assign bus.out_last  = out_vld && (j_q == CNT_W'(N - 1));
    assign err           = err_q;

endmodule

// File: tb/tb_ntt_bram_responder.sv
// Directed bench: load, engine run, result drain, protocol errors and mid-drain reset.
module tb_ntt_bram_responder;
    import ntt_bram_pkg::*;

    logic clk, rst_n, eng_rst, busy, err;
    logic [63:0] exp_out [N];
    int n_cmp = 0;
    int n_bad = 0;
    int fw, sp;

    ntt_bram_responder_if bus();

    ntt_bram_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .eng_rst (eng_rst),
        .busy    (busy),
        .err     (err)
    );

    assign bus.BRAM_clk = clk;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int off);
        bus.in_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
            bus.in_data = 64'(off + k);
            chk("in_ready_load", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("in_ready_drop", bus.in_ready, 0);
        chk("eng_rst_load_end", eng_rst, 1);
        @(negedge clk);
        chk("eng_rst_run", eng_rst, 0);
        chk("busy_run", busy, 1);
    endtask

    task automatic run_writes(input int off);
        for (int i = 0; i < N; i++) begin
            bus.BRAM_en   = 1'b1;
            bus.BRAM_we   = 1'b1;
            bus.BRAM_addr = ADDR_W'((OUT_BASE + i) << 2);
            bus.BRAM_din  = 64'(off + i);
            exp_out[i]    = 64'(off + i);
            chk("busy_writes", busy, 1);
            @(negedge clk);
        end
        bus.BRAM_en = 1'b0;
        bus.BRAM_we = 1'b0;
        chk("eng_rst_after_last_wr", eng_rst, 0);
        @(negedge clk);
        chk("drain_eng_rst", eng_rst, 1);
        chk("drain_busy", busy, 1);
    endtask

    task automatic drain(input logic [3:0] pat, input int stop_at, output int first_wait, output int span);
        int got, cyc;
        logic stalled;
        logic [63:0] held;
        got = 0; cyc = 0; stalled = 1'b0; held = '0; first_wait = -1; span = 0;
        while (got < stop_at && cyc < 1000) begin
            bus.out_ready = pat[cyc % 4];
            if (bus.out_valid) begin
                if (first_wait < 0) first_wait = cyc;
                if (stalled) chk("stall_hold", bus.out_data, held);
                if (bus.out_ready) begin
                    chk("out_data", bus.out_data, exp_out[got]);
                    chk("out_last", bus.out_last, (got == N - 1) ? 1 : 0);
                    got++;
                    stalled = 1'b0;
                    if (got == stop_at) span = cyc - first_wait + 1;
                end else begin
                    stalled = 1'b1;
                    held    = bus.out_data;
                end
            end else if (stalled) begin
                chk("valid_drop", 0, 1);
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (got < stop_at) chk("drain_timeout", 64'(got), 64'(stop_at));
    endtask

    initial begin
        rst_n = 1'b1;
        bus.BRAM_addr = '0; bus.BRAM_din = '0; bus.BRAM_en = 1'b0; bus.BRAM_we = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dout", bus.BRAM_dout, 0);
        chk("rst_eng_rst", eng_rst, 1);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", bus.in_ready, 1);

        // Load 0..63, engine reads them back with one-cycle latency
        load(0);
        bus.BRAM_en = 1'b1;
        bus.BRAM_we = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.BRAM_addr = ADDR_W'(i << 2);
            @(negedge clk);
            chk("porta_read", bus.BRAM_dout, 64'(i));
        end
        bus.BRAM_en = 1'b0;
        @(negedge clk);
        chk("dout_hold", bus.BRAM_dout, 63);
        run_writes(100);
        drain(4'b1111, N, fw, sp);
        chk("first_valid_lat", (fw >= 0 && fw <= 2) ? 1 : 0, 1);
        chk("no_bubbles", 64'(sp), 64'(N));
        chk("back_to_load", bus.in_ready, 1);
        chk("idle_busy", busy, 0);

        // Protocol errors in RUN, engine write in DRAIN, stalled drain
        load(500);
        chk("err_pre", err, 0);
        bus.BRAM_en = 1'b1; bus.BRAM_we = 1'b1;
        bus.BRAM_addr = ADDR_W'(5 << 2); bus.BRAM_din = 64'hBAD;
        @(negedge clk);
        chk("err_input_wr", err, 1);
        bus.BRAM_addr = ADDR_W'(200 << 2);
        @(negedge clk);
        chk("err_oob_wr", err, 1);
        bus.BRAM_we = 1'b0;
        bus.BRAM_addr = ADDR_W'(5 << 2);
        @(negedge clk);
        chk("word5_intact", bus.BRAM_dout, 505);
        bus.BRAM_addr = ADDR_W'(200 << 2);
        @(negedge clk);
        chk("oob_read_zero", bus.BRAM_dout, 0);
        bus.BRAM_en = 1'b0;
        run_writes(200);
        bus.BRAM_en = 1'b1; bus.BRAM_we = 1'b1;
        bus.BRAM_addr = ADDR_W'(70 << 2); bus.BRAM_din = 64'hDEAD;
        @(negedge clk);
        bus.BRAM_we = 1'b0;
        @(negedge clk);
        chk("drain_porta_read", bus.BRAM_dout, 206);
        chk("first_valid_stalled", bus.out_valid, 1);
        bus.BRAM_en = 1'b0;
        drain(4'b1001, N, fw, sp);
        chk("err_sticky", err, 1);

        // Reset in the middle of a drain, then a full clean pass
        load(300);
        run_writes(400);
        drain(4'b1111, 20, fw, sp);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_eng_rst", eng_rst, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1);
        load(600);
        run_writes(700);
        drain(4'b1111, N, fw, sp);
        chk("final_no_bubbles", 64'(sp), 64'(N));
        chk("final_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
